// File: rtl/ballot_collector.sv
// ballot_collector
//   Sequential front end that gathers one ballot per voter and publishes the
//   packed vote bus to the downstream combinational tally block.
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous active-high reset (priority over everything)
//     in_valid   ballot offered this cycle
//     in_ready   collector accepts ballots (high while collecting)
//     in_voter   voter ID of offered ballot (M bits)
//     in_choice  candidate chosen (N bits)
//     in_reject  one-cycle pulse: previously accepted ballot was a duplicate
//     close      end polling early and publish the current contents
//     vote       packed ballots, slot i at bits [(i+1)*N-1 : i*N]
//     voted      bit i set once voter i's ballot is stored
//     count      number of distinct voters stored (0..2**M)
//     out_valid  vote bus complete and stable
//     out_ack    consumer has taken the bus
//
//   Optional feature macro: BALLOT_REVOTE_EN
//     defined   - a duplicate ballot overwrites its slot; in_reject tied 0
//     undefined - duplicates are discarded and pulse in_reject
module ballot_collector #(
  parameter int              N              = 2,
  parameter int              M              = 2,
  parameter logic [N-1:0]    DEFAULT_CHOICE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [M-1:0]         in_voter,
  input  logic [N-1:0]         in_choice,
  output logic                 in_reject,
  input  logic                 close,
  output logic [(2**M)*N-1:0]  vote,
  output logic [2**M-1:0]      voted,
  output logic [M:0]           count,
  output logic                 out_valid,
  input  logic                 out_ack
);

  localparam int V = 2**M;
  localparam logic [M:0] C_LAST = (M+1)'(V - 1);

  typedef enum logic {COLLECT, PUBLISH} state_t;

  state_t          r_state;
  logic [N-1:0]    r_slot [V];
  logic [V-1:0]    r_voted;
  logic [M:0]      r_count;
  logic            r_in_ready;
  logic            r_out_valid;

  logic w_accept;
  logic w_new;
  logic w_dup;
  logic w_full;

  assign w_accept = in_valid && r_in_ready;
  assign w_new    = w_accept && !r_voted[in_voter];
  assign w_dup    = w_accept &&  r_voted[in_voter];
  // The ballot that fills the last empty slot triggers auto-publish.
  assign w_full   = w_new && (r_count == C_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_voted     <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      for (int i = 0; i < V; i++) r_slot[i] <= DEFAULT_CHOICE;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_new) begin
            r_slot[in_voter]  <= in_choice;
            r_voted[in_voter] <= 1'b1;
            r_count           <= r_count + 1'b1;
          end
`ifdef BALLOT_REVOTE_EN
          if (w_dup) r_slot[in_voter] <= in_choice;
`endif
          // A ballot accepted alongside close is stored above, so the
          // published bus already includes it.
          if (close || w_full) begin
            r_state     <= PUBLISH;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        PUBLISH: begin
          if (out_ack) begin
            r_state     <= COLLECT;
            r_voted     <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            for (int i = 0; i < V; i++) r_slot[i] <= DEFAULT_CHOICE;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

`ifdef BALLOT_REVOTE_EN
  assign in_reject = 1'b0;
`else
  logic r_reject;

  // Acceptance only happens while collecting, so this is naturally 0 in PUBLISH.
  always_ff @(posedge clk) begin
    if (rst) r_reject <= 1'b0;
    else     r_reject <= w_dup;
  end

  assign in_reject = r_reject;
`endif

  always_comb begin
    vote = '0;
    for (int i = 0; i < V; i++) vote[i*N +: N] = r_slot[i];
  end

  assign voted     = r_voted;
  assign count     = r_count;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

endmodule
